// File: rtl/bcd_byte_display_ctrl_pkg.sv
// Shared definitions for the AES block display sequencer: FSM states,
// block geometry and the blank code driven onto the digit bus.
package aes_disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_BYTES  = 16;
   localparam int NUM_DIGITS = 3;
   localparam int BYTE_IDX_W = $clog2(NUM_BYTES);

   localparam logic [3:0] BLANK_BCD = 4'hF;

   // Byte 0 lives in the most significant byte of the block.
   function automatic logic [7:0] block_byte(input logic [8*NUM_BYTES-1:0] blk,
                                             input logic [BYTE_IDX_W-1:0] idx);
      return blk[(NUM_BYTES - 1 - int'(idx)) * 8 +: 8];
   endfunction

endpackage

// File: rtl/bcd_byte_display_ctrl_if.sv
// Valid/ready handshake carrying one 128-bit AES block into the display
// sequencer.
interface bcd_byte_display_ctrl_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/bcd_byte_display_ctrl_bin2bcd.sv
// Combinational 8-bit binary to 3-digit BCD encoder (shift-and-add-3).
// Output is {hundreds, tens, ones}; hundreds never exceeds 2.
module bcd_byte_display_ctrl_bin2bcd (
   input  logic [7:0]  bin,
   output logic [11:0] bcd
);

   logic [19:0] shift;

   // Eight adjust-then-shift rounds move the binary value into the BCD field.
   always_comb begin
      shift = {12'h000, bin};
      for (int i = 0; i < 8; i++) begin
         if (shift[11:8] >= 4'd5) begin
            shift[11:8] = shift[11:8] + 4'd3;
         end
         if (shift[15:12] >= 4'd5) begin
            shift[15:12] = shift[15:12] + 4'd3;
         end
         if (shift[19:16] >= 4'd5) begin
            shift[19:16] = shift[19:16] + 4'd3;
         end
         shift = shift << 1;
      end
      bcd = shift[19:8];
   end

endmodule

// File: rtl/bcd_byte_display_ctrl.sv
// Walks a captured 128-bit AES block byte by byte through the BCD encoder
// and time-multiplexes the three decimal digits of the current byte onto
// a shared active-low 7-segment digit bus.
module bcd_byte_display_ctrl
   import aes_disp_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 50_000_000,
   parameter int unsigned SCAN_CYCLES  = 100_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   bcd_byte_display_ctrl_if.slave bus,
   input  logic                   auto_en,
   input  logic                   step,
   output logic                   busy,
   output logic [BYTE_IDX_W-1:0]  byte_idx,
   output logic [11:0]            bcd_digits,
   output logic [2:0]             digit_sel,
   output logic [3:0]             digit_bcd,
   output logic                   done
);

   localparam int DCNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int SCNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

   localparam logic [DCNT_W-1:0]     DWELL_LAST = DCNT_W'(DWELL_CYCLES - 1);
   localparam logic [SCNT_W-1:0]     SCAN_LAST  = SCNT_W'(SCAN_CYCLES - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_IDX   = BYTE_IDX_W'(NUM_BYTES - 1);
   localparam logic [1:0]            PHASE_LAST = 2'(NUM_DIGITS - 1);

   state_t                state;
   state_t                state_next;
   logic [127:0]          block;
   logic [DCNT_W-1:0]     dwell_cnt;
   logic [SCNT_W-1:0]     scan_cnt;
   logic [1:0]            phase;
   logic                  accept;
   logic                  advance;
   logic                  in_ready_w;
   logic [7:0]            cur_byte;
   logic [11:0]           enc_bcd;

   // State register; reset always lands back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status decode; a step and a dwell expiry in the same
   // cycle merge into a single advance.
   always_comb begin
      state_next = state;
      in_ready_w = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            in_ready_w = 1'b1;
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = SHOW;
            end
         end
         SHOW: begin
            busy = 1'b1;
            if (step || (auto_en && (dwell_cnt == DWELL_LAST))) begin
               advance = 1'b1;
               if (byte_idx == LAST_IDX) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.in_ready = in_ready_w;

   // Block capture, byte index and dwell counter; the counter parks at 0
   // whenever auto mode is off so re-enabling gives a full dwell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         block     <= '0;
         byte_idx  <= '0;
         dwell_cnt <= '0;
      end else if (accept) begin
         block     <= bus.in_data;
         byte_idx  <= '0;
         dwell_cnt <= '0;
      end else if (state == SHOW) begin
         if (advance) begin
            dwell_cnt <= '0;
            if (byte_idx != LAST_IDX) begin
               byte_idx <= byte_idx + BYTE_IDX_W'(1);
            end
         end else if (auto_en) begin
            dwell_cnt <= dwell_cnt + DCNT_W'(1);
         end else begin
            dwell_cnt <= '0;
         end
      end else begin
         dwell_cnt <= '0;
      end
   end

   assign cur_byte = block_byte(block, byte_idx);

   bcd_byte_display_ctrl_bin2bcd u_bin2bcd (
      .bin (cur_byte),
      .bcd (enc_bcd)
   );

   // Register the encoder output so bcd_digits trails byte_idx by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_digits <= 12'h000;
      end else begin
         bcd_digits <= enc_bcd;
      end
   end

   // Free-running scan timer; each wrap rotates ones -> tens -> hundreds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         phase    <= 2'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         phase    <= (phase == PHASE_LAST) ? 2'd0 : phase + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + SCNT_W'(1);
      end
   end

   // Registered digit bus, blanked whenever no block is being shown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_sel <= 3'b111;
         digit_bcd <= BLANK_BCD;
      end else if (state != SHOW) begin
         digit_sel <= 3'b111;
         digit_bcd <= BLANK_BCD;
      end else begin
         case (phase)
            2'd0: begin
               digit_sel <= 3'b110;
               digit_bcd <= bcd_digits[3:0];
            end
            2'd1: begin
               digit_sel <= 3'b101;
               digit_bcd <= bcd_digits[7:4];
            end
            default: begin
               digit_sel <= 3'b011;
               digit_bcd <= bcd_digits[11:8];
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_byte_display_ctrl.sv
// Directed self-checking bench for the AES byte display sequencer, run with
// a short dwell (4) and scan step (2) so whole blocks walk quickly.
module tb_bcd_byte_display_ctrl;

   localparam int DWELL = 4;
   localparam int SCAN  = 2;

   localparam logic [127:0] BLK_A = 128'hFF007F0A_01020304_05060708_090B0C64;
   localparam logic [127:0] BLK_B = 128'h7BC82A01_00000063_00000000_00000000;
   localparam logic [127:0] BLK_C = 128'h0A000000_00000000_00000000_00000000;

   logic        clk;
   logic        rst_n;
   logic        auto_en;
   logic        step;
   logic        busy;
   logic [3:0]  byte_idx;
   logic [11:0] bcd_digits;
   logic [2:0]  digit_sel;
   logic [3:0]  digit_bcd;
   logic        done;

   int errors = 0;
   int checks = 0;

   // Hand-computed decimal digits of each byte of BLK_A.
   logic [11:0] exp_a [16] = '{12'h255, 12'h000, 12'h127, 12'h010,
                               12'h001, 12'h002, 12'h003, 12'h004,
                               12'h005, 12'h006, 12'h007, 12'h008,
                               12'h009, 12'h011, 12'h012, 12'h100};

   // Scan rotation for 0x7B (123): ones, tens, hundreds, two cycles each.
   logic [2:0] scan_sel [7] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
   logic [3:0] scan_bcd [7] = '{4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1, 4'h3};

   bcd_byte_display_ctrl_if bus ();

   bcd_byte_display_ctrl #(
      .DWELL_CYCLES (DWELL),
      .SCAN_CYCLES  (SCAN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .auto_en    (auto_en),
      .step       (step),
      .busy       (busy),
      .byte_idx   (byte_idx),
      .bcd_digits (bcd_digits),
      .digit_sel  (digit_sel),
      .digit_bcd  (digit_bcd),
      .done       (done)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [127:0] d,
                                input logic a, input logic s);
      bus.in_valid = v;
      bus.in_data  = d;
      auto_en      = a;
      step         = s;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
      checkOutput({tag, "_busy"},      32'(busy),         32'd0);
      checkOutput({tag, "_done"},      32'(done),         32'd0);
      checkOutput({tag, "_byte_idx"},  32'(byte_idx),     32'd0);
      checkOutput({tag, "_bcd"},       32'(bcd_digits),   32'h000);
      checkOutput({tag, "_digit_sel"}, 32'(digit_sel),    32'b111);
      checkOutput({tag, "_digit_bcd"}, 32'(digit_bcd),    32'hF);
   endtask

   initial begin
      logic [2:0] prev_sel;
      bit         found;
      int         waited;

      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #12;
      checkResetValues("reset");

      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("idle_digit_sel", 32'(digit_sel), 32'b111);
      checkOutput("idle_digit_bcd", 32'(digit_bcd), 32'hF);

      // Auto walk of BLK_A with in_valid held high throughout; BLK_B is
      // put on the bus mid-walk and must only be taken in the first idle cycle.
      applyStimulus(1'b1, BLK_A, 1'b1, 1'b0);
      for (int c = 0; c <= 67; c++) begin
         @(negedge clk);
         if (c < 64) begin
            checkOutput($sformatf("walk_idx_c%0d", c), 32'(byte_idx), 32'(c / 4));
         end
         if (c >= 1 && c <= 64) begin
            checkOutput($sformatf("walk_bcd_c%0d", c), 32'(bcd_digits), 32'(exp_a[(c - 1) / 4]));
         end
         if (c <= 65) begin
            checkOutput($sformatf("walk_done_c%0d", c), 32'(done), 32'(c == 64));
            checkOutput($sformatf("walk_busy_c%0d", c), 32'(busy), 32'(c < 64));
            checkOutput($sformatf("walk_ready_c%0d", c), 32'(bus.in_ready), 32'(c == 65));
         end
         if (c == 66) begin
            checkOutput("b2b_busy", 32'(busy), 32'd1);
            checkOutput("b2b_idx", 32'(byte_idx), 32'd0);
         end
         if (c == 67) begin
            checkOutput("b2b_bcd", 32'(bcd_digits), 32'h123);
         end
         if (c == 2) applyStimulus(1'b1, BLK_B, 1'b1, 1'b0);
         if (c == 65) applyStimulus(1'b1, BLK_B, 1'b0, 1'b0);
         if (c == 66) applyStimulus(1'b0, BLK_B, 1'b0, 1'b0);
      end

      // Scan rotation while byte 0 of BLK_B (0x7B = 123) is shown.
      prev_sel = digit_sel;
      found    = 1'b0;
      waited   = 0;
      while (!found && waited < 12) begin
         @(negedge clk);
         waited++;
         if (prev_sel == 3'b011 && digit_sel == 3'b110) found = 1'b1;
         prev_sel = digit_sel;
      end
      checkOutput("scan_sync", 32'(found), 32'd1);
      if (found) begin
         for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("scan_sel_%0d", k), 32'(digit_sel), 32'(scan_sel[k]));
            checkOutput($sformatf("scan_bcd_%0d", k), 32'(digit_bcd), 32'(scan_bcd[k]));
         end
      end

      // Manual mode: no movement without a step.
      repeat (20) @(negedge clk);
      checkOutput("manual_hold_idx", 32'(byte_idx), 32'd0);
      checkOutput("manual_hold_busy", 32'(busy), 32'd1);

      applyStimulus(1'b0, BLK_B, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, BLK_B, 1'b0, 1'b0);
      checkOutput("step1_idx", 32'(byte_idx), 32'd1);
      @(negedge clk);
      checkOutput("step1_bcd", 32'(bcd_digits), 32'h200);

      applyStimulus(1'b0, BLK_B, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, BLK_B, 1'b0, 1'b0);
      checkOutput("step2_idx", 32'(byte_idx), 32'd2);
      @(negedge clk);
      checkOutput("step2_bcd", 32'(bcd_digits), 32'h042);

      // Step landing on the same cycle as dwell expiry: one advance only.
      applyStimulus(1'b0, BLK_B, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("coinc_pre1", 32'(byte_idx), 32'd2);
      @(negedge clk);
      @(negedge clk);
      checkOutput("coinc_pre3", 32'(byte_idx), 32'd2);
      applyStimulus(1'b0, BLK_B, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, BLK_B, 1'b0, 1'b0);
      checkOutput("coinc_idx", 32'(byte_idx), 32'd3);
      @(negedge clk);
      checkOutput("coinc_hold_idx", 32'(byte_idx), 32'd3);
      checkOutput("coinc_bcd", 32'(bcd_digits), 32'h001);

      // Step forward to byte 7 (0x63 = 099), then reset mid-walk.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, BLK_B, 1'b0, 1'b1);
         @(negedge clk);
         applyStimulus(1'b0, BLK_B, 1'b0, 1'b0);
         @(negedge clk);
      end
      checkOutput("pre_reset_idx", 32'(byte_idx), 32'd7);
      checkOutput("pre_reset_bcd", 32'(bcd_digits), 32'h099);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);

      rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus(1'b1, BLK_C, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, BLK_C, 1'b1, 1'b0);
      checkOutput("restart_busy", 32'(busy), 32'd1);
      checkOutput("restart_idx", 32'(byte_idx), 32'd0);
      @(negedge clk);
      checkOutput("restart_bcd", 32'(bcd_digits), 32'h010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
